// File: rtl/echo_delay_line_if.sv
// rtl/echo_delay_line_if.sv - sample stream in/out bundle for the echo delay line
interface echo_delay_line_if #(
    parameter int DATA_W = 12
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     in_valid;
    logic signed [DATA_W-1:0] sample_out;
    logic                     out_valid;

    modport master (
        output sample_in,
        output in_valid,
        input  sample_out,
        input  out_valid
    );

    modport slave (
        input  sample_in,
        input  in_valid,
        output sample_out,
        output out_valid
    );
endinterface

// File: rtl/echo_delay_line.sv
// rtl/echo_delay_line.sv - single-tap echo over a circular sample buffer with fill gating
module echo_delay_line #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    echo_delay_line_if.slave  io,
    input  logic              en,
    input  logic [ADDR_W-1:0] delay,
    input  logic [1:0]        atten,
    input  logic              fb_mode,
    output logic              fill_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_W-1:0]        wr_ptr_q;
    logic [ADDR_W-1:0]        cnt_q;
    logic [ADDR_W-1:0]        cnt_d;
    logic [ADDR_W-1:0]        cnt_inc;
    logic [ADDR_W-1:0]        delay_q;
    logic [ADDR_W-1:0]        delay_d;
    logic [ADDR_W-1:0]        rd_addr;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] echo_shift;
    logic signed [DATA_W-1:0] echo;
    logic signed [DATA_W:0]   wet_sum;
    logic signed [DATA_W-1:0] wet_sat;
    logic signed [DATA_W-1:0] wr_data;
    logic [2:0]               shift_amt;
    logic                     echo_on;

    // Read happens before this cycle's write, so delay=0 would alias the slot being overwritten.
    assign rd_addr    = wr_ptr_q - delay;
    assign rd_data    = mem[rd_addr];
    assign shift_amt  = {1'b0, atten} + 3'd1;
    assign echo_shift = rd_data >>> shift_amt;

    // The echo only exists once the tap has been filled for the current delay setting.
    assign echo_on = (state_q == RUN) && en && (delay != '0) && (delay == delay_q);
    assign echo    = echo_on ? echo_shift : '0;

    assign wet_sum = {io.sample_in[DATA_W-1], io.sample_in} + {echo[DATA_W-1], echo};
    assign wet_sat = (wet_sum[DATA_W] != wet_sum[DATA_W-1])
                   ? (wet_sum[DATA_W] ? SAT_MIN : SAT_MAX)
                   : wet_sum[DATA_W-1:0];

    assign wr_data   = fb_mode ? wet_sat : io.sample_in;
    assign cnt_inc   = cnt_q + 1'b1;
    assign fill_busy = (state_q == FILL);

    // Next-state logic; the machine only moves when a sample is consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        delay_d = delay_q;
        if (io.in_valid) begin
            case (state_q)
                IDLE: begin
                    if (en && (delay != '0)) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        delay_d = delay;
                    end
                end
                FILL, RUN: begin
                    if (!en || (delay == '0)) begin
                        state_d = IDLE;
                    end else if (delay != delay_q) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        delay_d = delay;
                    end else if (state_q == FILL) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == delay_q) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state and write pointer, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            delay_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delay_q <= delay_d;
            if (io.in_valid) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    // Delay buffer write; contents are left unreset since FILL keeps stale entries off the output.
    always_ff @(posedge clk) begin
        if (io.in_valid) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Output register: one-cycle latency, holds between valid samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io.sample_out <= '0;
            io.out_valid  <= 1'b0;
        end else begin
            io.out_valid <= io.in_valid;
            if (io.in_valid) begin
                io.sample_out <= en ? wet_sat : io.sample_in;
            end
        end
    end

endmodule

// File: tb/tb_echo_delay_line.sv
// tb/tb_echo_delay_line.sv - directed vector bench for echo_delay_line
module tb_echo_delay_line;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        bit    rst_before;
        int    x;
        bit    en;
        int    dly;
        int    atten;
        bit    fb;
        int    exp_out;
        bit    exp_fill;
        string name;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] delay;
    logic [1:0]        atten;
    logic              fb_mode;
    logic              fill_busy;

    int checks;
    int errors;

    vec_t tbl[$];

    echo_delay_line_if #(.DATA_W(DATA_W)) ifc ();

    echo_delay_line #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io       (ifc),
        .en       (en),
        .delay    (delay),
        .atten    (atten),
        .fb_mode  (fb_mode),
        .fill_busy(fill_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, int x, bit e, int d, int a, bit f, int eo, bit ef, string nm);
        vec_t v;
        v.rst_before = r;
        v.x          = x;
        v.en         = e;
        v.dly        = d;
        v.atten      = a;
        v.fb         = f;
        v.exp_out    = eo;
        v.exp_fill   = ef;
        v.name       = nm;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_sample_out", int'(ifc.sample_out), 0);
        chk("rst_fill_busy", int'(fill_busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drives one sample, waits for its edge and checks the registered result.
    task automatic apply(int x, bit e, int d, int a, bit f, int eo, bit ef, string nm);
        ifc.sample_in = DATA_W'(x);
        ifc.in_valid  = 1'b1;
        en            = e;
        delay         = ADDR_W'(d);
        atten         = 2'(a);
        fb_mode       = f;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, int'(ifc.out_valid), 1);
        chk({nm, "_out"}, int'(ifc.sample_out), eo);
        chk({nm, "_fill"}, int'(fill_busy), int'(ef));
    endtask

    initial begin
        int xs[64];
        int e;
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        ifc.sample_in = '0;
        ifc.in_valid  = 1'b0;
        en            = 1'b0;
        delay         = '0;
        atten         = '0;
        fb_mode       = 1'b0;

        // Dry pass-through
        tbl.push_back(mk(1,  100, 0, 0, 0, 0,  100, 0, "dry0"));
        tbl.push_back(mk(0,  200, 0, 0, 0, 0,  200, 0, "dry1"));
        tbl.push_back(mk(0,   -5, 0, 0, 0, 0,   -5, 0, "dry2"));
        // Feed-forward impulse, delay 3 (first sample primes the fill)
        tbl.push_back(mk(1,    0, 1, 3, 0, 0,    0, 1, "ff0"));
        tbl.push_back(mk(0, 1000, 1, 3, 0, 0, 1000, 1, "ff1"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,    0, 1, "ff2"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,    0, 0, "ff3"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,  500, 0, "ff4"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,    0, 0, "ff5"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,    0, 0, "ff6"));
        tbl.push_back(mk(0,    0, 1, 3, 0, 0,    0, 0, "ff7"));
        // Feedback impulse, delay 2
        tbl.push_back(mk(1,    0, 1, 2, 0, 1,    0, 1, "fb0"));
        tbl.push_back(mk(0,  800, 1, 2, 0, 1,  800, 1, "fb1"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,    0, 0, "fb2"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,  400, 0, "fb3"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,    0, 0, "fb4"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,  200, 0, "fb5"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,    0, 0, "fb6"));
        tbl.push_back(mk(0,    0, 1, 2, 0, 1,  100, 0, "fb7"));
        // Saturation at delay 1, then attenuation settings
        tbl.push_back(mk(1,  2047, 1, 1, 0, 0,  2047, 1, "sat0"));
        tbl.push_back(mk(0,  2047, 1, 1, 0, 0,  2047, 0, "sat1"));
        tbl.push_back(mk(0,  2047, 1, 1, 0, 0,  2047, 0, "sat2"));
        tbl.push_back(mk(0,  2047, 1, 1, 0, 0,  2047, 0, "sat3"));
        tbl.push_back(mk(0, -2048, 1, 1, 0, 0, -1025, 0, "sat4"));
        tbl.push_back(mk(0, -2048, 1, 1, 0, 0, -2048, 0, "sat5"));
        tbl.push_back(mk(0, -2048, 1, 1, 0, 0, -2048, 0, "sat6"));
        tbl.push_back(mk(0,   100, 1, 1, 3, 0,   -28, 0, "att3"));
        tbl.push_back(mk(0,     0, 1, 1, 1, 0,    25, 0, "att1"));
        tbl.push_back(mk(0,    -7, 1, 1, 2, 0,    -7, 0, "att2a"));
        tbl.push_back(mk(0,     0, 1, 1, 2, 0,    -1, 0, "att2b"));
        // Delay change 3 -> 5 while running, then en drop and re-entry
        tbl.push_back(mk(1,   10, 1, 3, 0, 0,   10, 1, "chg0"));
        tbl.push_back(mk(0,   20, 1, 3, 0, 0,   20, 1, "chg1"));
        tbl.push_back(mk(0,   30, 1, 3, 0, 0,   30, 1, "chg2"));
        tbl.push_back(mk(0,   40, 1, 3, 0, 0,   40, 0, "chg3"));
        tbl.push_back(mk(0,   50, 1, 3, 0, 0,   60, 0, "chg4"));
        tbl.push_back(mk(0,   60, 1, 3, 0, 0,   75, 0, "chg5"));
        tbl.push_back(mk(0,   70, 1, 5, 0, 0,   70, 1, "chg6"));
        tbl.push_back(mk(0,   80, 1, 5, 0, 0,   80, 1, "chg7"));
        tbl.push_back(mk(0,   90, 1, 5, 0, 0,   90, 1, "chg8"));
        tbl.push_back(mk(0,  100, 1, 5, 0, 0,  100, 1, "chg9"));
        tbl.push_back(mk(0,  110, 1, 5, 0, 0,  110, 1, "chg10"));
        tbl.push_back(mk(0,  120, 1, 5, 0, 0,  120, 0, "chg11"));
        tbl.push_back(mk(0,  130, 1, 5, 0, 0,  170, 0, "chg12"));
        tbl.push_back(mk(0,  140, 1, 5, 0, 0,  185, 0, "chg13"));
        tbl.push_back(mk(0,    5, 0, 5, 0, 0,    5, 0, "chg14"));
        tbl.push_back(mk(0,    6, 1, 5, 0, 0,    6, 1, "chg15"));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            apply(tbl[i].x, tbl[i].en, tbl[i].dly, tbl[i].atten, tbl[i].fb,
                  tbl[i].exp_out, tbl[i].exp_fill, tbl[i].name);
            // A bubble after the dry stream: no valid pulse, output held
            if (tbl[i].name == "dry2") begin
                ifc.in_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("gap_valid", int'(ifc.out_valid), 0);
                chk("gap_hold", int'(ifc.sample_out), -5);
            end
        end
        ifc.in_valid = 1'b0;

        // Delay 15 over 40 samples: pointer wraps, echo is x[n-15]/2 from n=16 on
        do_reset();
        for (int n = 0; n < 40; n++) begin
            xs[n] = n * 10 - 150;
            e = (n >= 16) ? (xs[n-15] >>> 1) : 0;
            apply(xs[n], 1, 15, 0, 0, xs[n] + e, n <= 14, $sformatf("wrap%0d", n));
        end

        // Asynchronous reset mid-stream, away from the clock edge
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(ifc.out_valid), 0);
        chk("mid_rst_out", int'(ifc.sample_out), 0);
        chk("mid_rst_fill", int'(fill_busy), 0);
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // After release a complete new fill is needed before any echo
        for (int m = 0; m < 20; m++) begin
            xs[m] = 300 - 7 * m;
            e = (m >= 16) ? (xs[m-15] >>> 1) : 0;
            apply(xs[m], 1, 15, 0, 0, xs[m] + e, m <= 14, $sformatf("post%0d", m));
        end
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("end_valid", int'(ifc.out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
